// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the digit-serial adder/subtractor.
// master drives the request side, slave (the datapath) drives results.
interface serial_add_sub_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, mode, a, b,
        input  busy, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB first, carry held in a flop.
// Start/busy/done handshake; results only update at the completion edge.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_sub_if.slave    bus
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   dig_sum;
    logic [DIGIT:0]     dig_c;
    logic               last_digit;

    // DIGIT-bit ripple of full-adder cells fed by the carry flop
    always_comb begin
        dig_c    = '0;
        dig_sum  = '0;
        dig_c[0] = carry_q;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            dig_sum[i]  = a_q[i] ^ b_q[i] ^ dig_c[i];
            dig_c[i+1]  = (a_q[i] & b_q[i]) | (dig_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    assign last_digit = (cnt_q == CNT_W'(N - 1));

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.mode ? ~bus.b : bus.b;
                    carry_d = bus.mode;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end

            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                part_d  = (part_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
                carry_d = dig_c[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    // Carry into the MSB is the carry into the top cell of the last digit
                    sum_d   = part_d;
                    cout_d  = dig_c[DIGIT];
                    ovf_d   = dig_c[DIGIT-1] ^ dig_c[DIGIT];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: bit-serial (DIGIT=1) and nibble-serial (DIGIT=4) instances
// checked against hand-computed values and a behavioural reference.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8)) if8 ();
    serial_add_sub_if #(.WIDTH(8)) if4 ();

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(if8));
    serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic md,
                         input logic [7:0] av, input logic [7:0] bv);
        if (sel == 0) begin
            if8.start = st; if8.mode = md; if8.a = av; if8.b = bv;
        end else begin
            if4.start = st; if4.mode = md; if4.a = av; if4.b = bv;
        end
    endtask

    task automatic sample(input int sel, output logic bz, output logic dn,
                          output logic [7:0] s, output logic co, output logic ov);
        if (sel == 0) begin
            bz = if8.busy; dn = if8.done; s = if8.sum; co = if8.carry_out; ov = if8.overflow;
        end else begin
            bz = if4.busy; dn = if4.done; s = if4.sum; co = if4.carry_out; ov = if4.overflow;
        end
    endtask

    // Reference built from plain integer arithmetic
    task automatic ref_op(input logic md, input logic [7:0] av, input logic [7:0] bv,
                          output logic [7:0] s, output logic co, output logic ov);
        logic [8:0] full;
        if (!md) begin
            full = {1'b0, av} + {1'b0, bv};
            s    = full[7:0];
            co   = full[8];
            ov   = (av[7] == bv[7]) && (s[7] != av[7]);
        end else begin
            s    = av - bv;
            co   = (av >= bv);
            ov   = (av[7] != bv[7]) && (s[7] != av[7]);
        end
    endtask

    // One full transaction: start pulse, wait (bounded) for done, check timing and results
    task automatic run_op(input int sel, input int n, input logic md,
                          input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] es, input logic eco, input logic eov,
                          input string tag);
        logic bz, dn, co, ov;
        logic [7:0] s;
        int cyc, bcnt;
        drive(sel, 1'b1, md, av, bv);
        tick;
        drive(sel, 1'b0, ~md, 8'($urandom), 8'($urandom));
        cyc = 0; bcnt = 0;
        sample(sel, bz, dn, s, co, ov);
        while (!dn && cyc < 40) begin
            if (bz) bcnt++;
            tick;
            cyc++;
            sample(sel, bz, dn, s, co, ov);
        end
        check({tag, "_edges"}, 32'(cyc + 1), 32'(n + 1));
        check({tag, "_busycnt"}, 32'(bcnt), 32'(n));
        check({tag, "_busy_at_done"}, 32'(bz), 32'd0);
        check({tag, "_sum"}, 32'(s), 32'(es));
        check({tag, "_cout"}, 32'(co), 32'(eco));
        check({tag, "_ovf"}, 32'(ov), 32'(eov));
        tick;
        sample(sel, bz, dn, s, co, ov);
        check({tag, "_done_one_cycle"}, 32'(dn), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bz, dn, co, ov;
        logic [7:0] s;
        logic [7:0] es;
        logic eco, eov;
        int ndone, nboth;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        // start together with rst must be dropped
        drive(0, 1'b1, 1'b0, 8'h12, 8'h34);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        for (int sel = 0; sel < 2; sel++) begin
            sample(sel, bz, dn, s, co, ov);
            check($sformatf("reset%0d_busy", sel), 32'(bz), 32'd0);
            check($sformatf("reset%0d_done", sel), 32'(dn), 32'd0);
            check($sformatf("reset%0d_sum", sel), 32'(s), 32'd0);
            check($sformatf("reset%0d_cout", sel), 32'(co), 32'd0);
            check($sformatf("reset%0d_ovf", sel), 32'(ov), 32'd0);
        end
        tick;
        sample(0, bz, dn, s, co, ov);
        check("rst_start_dropped_busy", 32'(bz), 32'd0);

        // T1..T3 on the bit-serial instance
        run_op(0, 8, 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, "t1_add");
        run_op(0, 8, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "t2_wrap");
        run_op(0, 8, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "t2_ovf");
        run_op(0, 8, 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, "t3_borrow");
        run_op(0, 8, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "t3_ovf");

        // T4: start pulse during RUN is ignored; prior sum held until completion
        drive(0, 1'b1, 1'b0, 8'h01, 8'h01);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        tick;
        drive(0, 1'b1, 1'b0, 8'h11, 8'h22);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        sample(0, bz, dn, s, co, ov);
        check("t4_sum_held", 32'(s), 32'h7F);
        check("t4_flags_held", 32'({co, ov}), 32'b11);
        ndone = 0; nboth = 0; es = 8'hxx;
        for (int i = 0; i < 30; i++) begin
            sample(0, bz, dn, s, co, ov);
            if (dn) begin
                ndone++;
                if (ndone == 1) es = s;
            end
            if (bz && dn) nboth++;
            tick;
        end
        check("t4_done_count", 32'(ndone), 32'd1);
        check("t4_sum", 32'(es), 32'h02);
        check("t4_busy_and_done", 32'(nboth), 32'd0);

        // T5: reset at the 4th RUN cycle abandons the operation
        drive(0, 1'b1, 1'b0, 8'h55, 8'h0A);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        sample(0, bz, dn, s, co, ov);
        check("t5_busy", 32'(bz), 32'd0);
        check("t5_done", 32'(dn), 32'd0);
        check("t5_sum", 32'(s), 32'd0);
        check("t5_flags", 32'({co, ov}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick;
            sample(0, bz, dn, s, co, ov);
            if (dn) check("t5_no_late_done", 32'(dn), 32'd0);
        end
        run_op(0, 8, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, "t5_after");

        // T6: nibble-serial instance
        run_op(1, 2, 1'b0, 8'h9A, 8'h76, 8'h10, 1'b1, 1'b0, "t6_add");
        run_op(1, 2, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, "t6_sub_ovf");
        for (int i = 0; i < 1000; i++) begin
            logic md;
            logic [7:0] av, bv;
            md = 1'($urandom);
            av = 8'($urandom);
            bv = 8'($urandom);
            ref_op(md, av, bv, es, eco, eov);
            run_op(1, 2, md, av, bv, es, eco, eov, $sformatf("t6_rnd%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            logic md;
            logic [7:0] av, bv;
            md = 1'($urandom);
            av = 8'($urandom);
            bv = 8'($urandom);
            ref_op(md, av, bv, es, eco, eov);
            run_op(0, 8, md, av, bv, es, eco, eov, $sformatf("d1_rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
